// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte-lane write enables, 1- or 2-cycle read latency,
// selectable read/write collision policy, out-of-range flags and a sequential clear engine.
module ram_sdp_be #(
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 12,
    parameter int WIDTH    = 32,
    parameter int BYTE_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_req,
    output logic                      busy,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH/BYTE_W-1:0]   wr_be,
    input  logic [WIDTH-1:0]          wr_data,
    output logic                      wr_err,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      rd_err
);

    localparam int NB = WIDTH / BYTE_W;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] merge_lanes(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] new_word,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) begin
                res[k*BYTE_W +: BYTE_W] = new_word[k*BYTE_W +: BYTE_W];
            end else begin
                res[k*BYTE_W +: BYTE_W] = old_word[k*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] ptr_r, ptr_s;
    logic              busy_r;
    logic              wr_err_r;

    logic              ready_s;
    logic              wr_in_s, rd_in_s;
    logic              wr_ok_s, wr_bad_s, rd_acc_s;
    logic [ADDR_W-1:0] wr_idx_s, rd_idx_s;
    logic [WIDTH-1:0]  wr_word_s, rd_word_s;

    logic              valid1_r, err1_r;
    logic [WIDTH-1:0]  data1_r;

    // Request qualification; out-of-range addresses are steered to word 0 so the array is never over-indexed.
    always_comb begin
        ready_s  = (state_r == ST_READY);
        wr_in_s  = ({1'b0, wr_addr} < DEPTH_L);
        rd_in_s  = ({1'b0, rd_addr} < DEPTH_L);
        wr_ok_s  = ready_s && wr_en && wr_in_s;
        wr_bad_s = ready_s && wr_en && !wr_in_s;
        rd_acc_s = ready_s && rd_en;
        wr_idx_s = wr_in_s ? wr_addr : '0;
        rd_idx_s = rd_in_s ? rd_addr : '0;
        wr_word_s = merge_lanes(mem[wr_idx_s], wr_data, wr_be);
    end

    // Read word selection, including the same-address collision bypass.
    always_comb begin
        rd_word_s = '0;
        if (!rd_in_s) begin
            rd_word_s = '0;
        end else if ((WR_FIRST != 0) && wr_ok_s && (wr_addr == rd_addr)) begin
            rd_word_s = wr_word_s;
        end else begin
            rd_word_s = mem[rd_idx_s];
        end
    end

    // Clear-engine next state: walk every word once, then serve traffic until a clear request.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        case (state_r)
            ST_CLEAR: begin
                if (ptr_r == LAST_ADDR) begin
                    state_s = ST_READY;
                    ptr_s   = '0;
                end else begin
                    state_s = ST_CLEAR;
                    ptr_s   = ptr_r + ADDR_W'(1);
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_s = ST_CLEAR;
                    ptr_s   = '0;
                end else begin
                    state_s = ST_READY;
                    ptr_s   = ptr_r;
                end
            end
            default: begin
                state_s = ST_CLEAR;
                ptr_s   = '0;
            end
        endcase
    end

    // Control state, busy flag and write-error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_CLEAR;
            ptr_r    <= '0;
            busy_r   <= 1'b1;
            wr_err_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            busy_r   <= (state_s == ST_CLEAR);
            wr_err_r <= wr_bad_s;
        end
    end

    // Storage array; no reset here, the clear engine owns zeroing.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem[ptr_r] <= '0;
        end else if (wr_ok_s) begin
            mem[wr_idx_s] <= wr_word_s;
        end
    end

    // First read stage; data is held between accepted reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid1_r <= 1'b0;
            err1_r   <= 1'b0;
            data1_r  <= '0;
        end else begin
            valid1_r <= rd_acc_s;
            err1_r   <= rd_acc_s && !rd_in_s;
            if (rd_acc_s) begin
                data1_r <= rd_word_s;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             valid2_r, err2_r;
            logic [WIDTH-1:0] data2_r;

            // Second read stage, advancing only on valid data so the output holds otherwise.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid2_r <= 1'b0;
                    err2_r   <= 1'b0;
                    data2_r  <= '0;
                end else begin
                    valid2_r <= valid1_r;
                    err2_r   <= err1_r;
                    if (valid1_r) begin
                        data2_r <= data1_r;
                    end
                end
            end

            assign rd_valid = valid2_r;
            assign rd_err   = err2_r;
            assign rd_data  = data2_r;
        end else begin : g_lat1
            assign rd_valid = valid1_r;
            assign rd_err   = err1_r;
            assign rd_data  = data1_r;
        end
    endgenerate

    assign busy   = busy_r;
    assign wr_err = wr_err_r;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Self-checking bench: two instances (RD_LAT=1/WR_FIRST=1 and RD_LAT=2/WR_FIRST=0) share stimulus;
// expected reads are queued with their due cycle and checked when the instance produces them.
module tb_ram_sdp_be;

    localparam int DEPTH = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [3:0]  wr_be = 4'd0;
    logic [31:0] wr_data = 32'd0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = 4'd0;

    logic        busy_v [2];
    logic        wr_err_v [2];
    logic        rd_valid_v [2];
    logic        rd_err_v [2];
    logic [31:0] rd_data_v [2];

    typedef struct {
        logic        wen;
        logic [3:0]  waddr;
        logic [3:0]  wbe;
        logic [31:0] wdata;
        logic        ren;
        logic [3:0]  raddr;
        logic        clr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_wr_err_cyc = -10;
    logic        m_clear = 1'b1;
    int          m_ptr = 0;
    exp_t        q [2][$];
    logic [31:0] last_v [2];
    vec_t        tbl [20];
    int          nbusy;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ram_sdp_be #(.ADDR_W(4), .DEPTH(DEPTH), .WIDTH(32), .BYTE_W(8), .RD_LAT(1), .WR_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_v[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_err(wr_err_v[0]),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_v[0]), .rd_valid(rd_valid_v[0]),
        .rd_err(rd_err_v[0])
    );

    ram_sdp_be #(.ADDR_W(4), .DEPTH(DEPTH), .WIDTH(32), .BYTE_W(8), .RD_LAT(2), .WR_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_v[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_err(wr_err_v[1]),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_v[1]), .rd_valid(rd_valid_v[1]),
        .rd_err(rd_err_v[1])
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic [3:0] waddr, input logic [3:0] wbe,
                                input logic [31:0] wdata, input logic ren, input logic [3:0] raddr,
                                input logic clr, input logic [31:0] exp_a, input logic [31:0] exp_b,
                                input logic exp_err);
        vec_t v;
        v.wen = wen; v.waddr = waddr; v.wbe = wbe; v.wdata = wdata;
        v.ren = ren; v.raddr = raddr; v.clr = clr;
        v.exp_a = exp_a; v.exp_b = exp_b; v.exp_err = exp_err;
        return v;
    endfunction

    function automatic vec_t wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        return mk(1'b1, a, be, d, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    endfunction

    function automatic vec_t rd(input logic [3:0] a, input logic [31:0] ea, input logic [31:0] eb,
                                input logic ee);
        return mk(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, a, 1'b0, ea, eb, ee);
    endfunction

    function automatic vec_t idle();
        return mk(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    endfunction

    // Drive one cycle of stimulus (called at a falling edge) and record what it should produce.
    task automatic step(input vec_t v);
        exp_t e;
        wr_en = v.wen; wr_addr = v.waddr; wr_be = v.wbe; wr_data = v.wdata;
        rd_en = v.ren; rd_addr = v.raddr; clr_req = v.clr;
        if (!m_clear) begin
            if (v.ren) begin
                e.err = v.exp_err;
                e.due = cyc + 1; e.data = v.exp_a; q[0].push_back(e);
                e.due = cyc + 2; e.data = v.exp_b; q[1].push_back(e);
            end
            if (v.wen && (v.waddr >= 4'd12)) exp_wr_err_cyc = cyc + 1;
        end
        if (m_clear) begin
            if (m_ptr == DEPTH - 1) m_clear = 1'b0;
            m_ptr++;
        end else if (v.clr) begin
            m_clear = 1'b1;
            m_ptr = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        q[0].delete(); q[1].delete();
        m_clear = 1'b1; m_ptr = 0; exp_wr_err_cyc = -10;
        last_v[0] = 32'd0; last_v[1] = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy_v[0]) n++;
            else break;
            step(idle());
        end
    endtask

    // Output monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                chk("rst_busy", d, busy_v[d], 32'd1);
                chk("rst_rd_valid", d, rd_valid_v[d], 32'd0);
                chk("rst_rd_data", d, rd_data_v[d], 32'd0);
                chk("rst_errs", d, {wr_err_v[d], rd_err_v[d]}, 32'd0);
            end else begin
                chk("busy", d, busy_v[d], m_clear);
                chk("wr_err", d, wr_err_v[d], (cyc == exp_wr_err_cyc));
                if (rd_valid_v[d]) begin
                    if (q[d].size() == 0) begin
                        chk("spurious_rd_valid", d, rd_valid_v[d], 32'd0);
                    end else begin
                        e = q[d].pop_front();
                        chk("rd_latency_cycle", d, cyc, e.due);
                        chk("rd_data", d, rd_data_v[d], e.data);
                        chk("rd_err", d, rd_err_v[d], e.err);
                        last_v[d] = e.data;
                    end
                end else begin
                    chk("rd_data_hold", d, rd_data_v[d], last_v[d]);
                    if ((q[d].size() > 0) && (q[d][0].due <= cyc)) begin
                        chk("missing_rd_valid", d, rd_valid_v[d], 32'd1);
                        void'(q[d].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        tbl[0]  = wr(4'd3, 4'hF, 32'hAABBCCDD);
        tbl[1]  = wr(4'd3, 4'b0101, 32'h11223344);
        tbl[2]  = rd(4'd3, 32'hAA22CC44, 32'hAA22CC44, 1'b0);
        tbl[3]  = wr(4'd5, 4'hF, 32'h12345678);
        tbl[4]  = mk(1'b1, 4'd5, 4'b1100, 32'hFFFF0000, 1'b1, 4'd5, 1'b0,
                     32'hFFFF5678, 32'h12345678, 1'b0);
        tbl[5]  = rd(4'd5, 32'hFFFF5678, 32'hFFFF5678, 1'b0);
        tbl[6]  = wr(4'd13, 4'hF, 32'hDEADDEAD);
        tbl[7]  = rd(4'd14, 32'd0, 32'd0, 1'b1);
        tbl[8]  = rd(4'd0, 32'd0, 32'd0, 1'b0);
        tbl[9]  = wr(4'd1, 4'hF, 32'h1);
        tbl[10] = wr(4'd2, 4'hF, 32'h2);
        tbl[11] = wr(4'd3, 4'hF, 32'h3);
        tbl[12] = rd(4'd1, 32'h1, 32'h1, 1'b0);
        tbl[13] = rd(4'd2, 32'h2, 32'h2, 1'b0);
        tbl[14] = rd(4'd3, 32'h3, 32'h3, 1'b0);
        tbl[15] = wr(4'd4, 4'h0, 32'hFFFFFFFF);
        tbl[16] = rd(4'd4, 32'd0, 32'd0, 1'b0);
        tbl[17] = mk(1'b1, 4'd6, 4'b0011, 32'hCAFEBEEF, 1'b1, 4'd7, 1'b0, 32'd0, 32'd0, 1'b0);
        tbl[18] = rd(4'd6, 32'h0000BEEF, 32'h0000BEEF, 1'b0);
        tbl[19] = wr(4'd7, 4'hF, 32'hDEADBEEF);

        last_v[0] = 32'd0; last_v[1] = 32'd0;
        @(negedge clk);
        do_reset();
        count_busy(nbusy);
        chk("clear_cycles_after_reset", 0, nbusy, 32'd12);
        for (int a = 0; a < DEPTH; a++) step(rd(4'(a), 32'd0, 32'd0, 1'b0));

        for (int i = 0; i < 20; i++) step(tbl[i]);

        // Clear request with a read in the same cycle, then traffic that must be ignored while busy.
        step(mk(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd7, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0));
        for (int i = 0; (i < 30) && m_clear; i++)
            step(mk(1'b1, 4'd7, 4'hF, 32'hFFFFFFFF, 1'b1, 4'd7, 1'b0, 32'd0, 32'd0, 1'b0));
        step(rd(4'd7, 32'd0, 32'd0, 1'b0));

        // Reset in the middle of a clear restarts the full walk.
        step(wr(4'd9, 4'hF, 32'h99999999));
        step(mk(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 32'd0, 32'd0, 1'b0));
        repeat (5) step(idle());
        do_reset();
        count_busy(nbusy);
        chk("clear_cycles_after_midclear_reset", 0, nbusy, 32'd12);
        for (int a = 0; a < DEPTH; a++) step(rd(4'(a), 32'd0, 32'd0, 1'b0));

        repeat (4) step(idle());
        chk("queue_drained", 0, q[0].size(), 32'd0);
        chk("queue_drained", 1, q[1].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Parametrised simple-dual-port RAM: one write port and one read port, usable in the same cycle.
- Adds per-byte write enables, configurable read latency, defined read/write collision behaviour and out-of-range error flags.
- A sequential clear engine zeroes memory after reset or on request, replacing a combinational full-array reset.
- Drop-in storage for register files and small buffers in the datapath.

Parameters:
- ADDR_W, 4, address width of both ports.
- DEPTH, 12, number of words; DEPTH <= 2**ADDR_W.
- WIDTH, 32, data word width; must be a multiple of BYTE_W.
- BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W lanes.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- WR_FIRST, 1, collision policy: 1 = read returns newly written data, 0 = read returns old data.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active low.
- clr_req  in  1  single-cycle pulse; starts a memory clear.
- busy  out  1  high while the clear engine runs.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_be  in  NB  byte-lane enables; bit k covers wr_data[k*BYTE_W +: BYTE_W].
- wr_data  in  WIDTH  write data.
- wr_err  out  1  one-cycle pulse: write dropped because wr_addr >= DEPTH.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_err  out  1  read address was >= DEPTH; aligned with rd_valid.

Behaviour:
- Reset values (rst low): rd_data=0, rd_valid=0, rd_err=0, wr_err=0, busy=1, FSM=CLEAR, clear pointer=0.
- Memory contents are not reset asynchronously; the clear engine zeroes them.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[ptr] and increments ptr. When ptr == DEPTH-1 is written, go to READY; busy falls on the next edge. Clear takes DEPTH cycles.
  - READY: normal operation. clr_req=1 sets ptr=0 and goes to CLEAR, with busy=1 from the next cycle.
- While busy=1:
  - wr_en is ignored; no wr_err is raised.
  - rd_en is not accepted; rd_valid stays 0.
  - clr_req is ignored.
- Reset asserted mid-clear restarts the clear from address 0.
- Write (READY, wr_en=1, wr_addr < DEPTH): at the clock edge, lanes with wr_be[k]=1 update; other lanes keep their value.
  - wr_be=0 is a legal no-op, with no error.
  - wr_addr >= DEPTH: memory is unchanged and wr_err=1 for exactly the following cycle.
- Read (READY, rd_en=1), RD_LAT=1:
  - rd_data and rd_valid update on the next edge. rd_valid is a one-cycle pulse per accepted read.
  - rd_addr >= DEPTH: rd_data=0 and rd_err=1, both with rd_valid.
- Read with RD_LAT=2: one extra register stage on rd_data, rd_valid and rd_err. Back-to-back reads are fully pipelined, one result per cycle, in order.
- rd_data holds its last value when rd_valid=0; it is not cleared.
- Collision (wr_en and rd_en in the same cycle, same in-range address):
  - WR_FIRST=1: read returns the merged word (old data with enabled lanes replaced).
  - WR_FIRST=0: read returns the pre-write word.
- Writes and reads to different addresses in the same cycle proceed independently.
- A clr_req accepted in READY does not affect reads already in the RD_LAT pipeline; they complete with their captured data.

Test Plan:
- Reset release with DEPTH=12: busy=1 for 12 cycles then 0; read of every address 0..11 returns 0x00000000 with rd_valid one cycle later.
- Byte enables: write 0xAABBCCDD to addr 3 with be=4'hF, then 0x11223344 with be=4'b0101; read addr 3 -> 0xAA22CC44.
- Collision: mem[5]=0x12345678; same cycle write 0xFFFF0000 be=4'b1100 and read addr 5. WR_FIRST=1 -> 0xFFFF5678; WR_FIRST=0 -> 0x12345678.
- Out of range: write addr 13 -> wr_err pulse, mem[0..11] unchanged; read addr 14 -> rd_data=0, rd_valid=1, rd_err=1.
- RD_LAT=2 pipelining: reads on consecutive cycles to addrs 1,2,3 holding 0x1,0x2,0x3 -> rd_valid high for 3 cycles starting 2 cycles after the first read, data 0x1,0x2,0x3 in order.
- Clear during operation: fill addr 7 = 0xDEADBEEF, pulse clr_req, assert rd_en and wr_en while busy -> no rd_valid, no write; after busy falls, read addr 7 -> 0. Assert rst at clear cycle 5 -> a full 12-cycle clear restarts.
